// File: rtl/jtag_tap_controller.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_controller
// Description : IEEE 1149.1 TAP controller with 4-bit IR, BYPASS and IDCODE
//               data registers, and the negedge-registered TDO mux feeding
//               the die TDO pin. DWR capture/shift/update live downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_controller #(
    parameter logic [31:0] IDCODE_VALUE = 32'h1234_5001,
    parameter logic [3:0]  IR_RESET     = 4'b0001
) (
    input  logic       TCK,
    input  logic       TRST_N,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       wrapper_tdo,
    output logic [3:0] tap_state,
    output logic [3:0] IR,
    output logic       TDO,
    output logic       tdo_en
);

    localparam logic [3:0] c_EX2DR = 4'h0;
    localparam logic [3:0] c_EX1DR = 4'h1;
    localparam logic [3:0] c_SHDR  = 4'h2;
    localparam logic [3:0] c_PSDR  = 4'h3;
    localparam logic [3:0] c_SELIR = 4'h4;
    localparam logic [3:0] c_UPDDR = 4'h5;
    localparam logic [3:0] c_CAPDR = 4'h6;
    localparam logic [3:0] c_SELDR = 4'h7;
    localparam logic [3:0] c_EX2IR = 4'h8;
    localparam logic [3:0] c_EX1IR = 4'h9;
    localparam logic [3:0] c_SHIR  = 4'hA;
    localparam logic [3:0] c_PSIR  = 4'hB;
    localparam logic [3:0] c_RTI   = 4'hC;
    localparam logic [3:0] c_UPDIR = 4'hD;
    localparam logic [3:0] c_CAPIR = 4'hE;
    localparam logic [3:0] c_TLR   = 4'hF;

    localparam logic [3:0] c_IR_CAPTURE = 4'b0001;

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [3:0]  r_ir;
    logic [3:0]  r_ir_sr;
    logic        r_bypass;
    logic [31:0] r_id_sr;
    logic        r_tdo;
    logic        r_tdo_en;
    logic        w_sel_dwr;
    logic        w_sel_id;
    logic        w_tdo;
    logic        w_shifting;

    // EXTEST, INTEST and SAMPLE route to the DWR; unassigned codes fall to bypass
    assign w_sel_dwr = (r_ir == 4'b0000) || (r_ir == 4'b0010) || (r_ir == 4'b0100);
    assign w_sel_id  = (r_ir == 4'b0001);

    always_comb begin
        w_next = c_TLR;
        case (r_state)
            c_TLR:   w_next = TMS ? c_TLR   : c_RTI;
            c_RTI:   w_next = TMS ? c_SELDR : c_RTI;
            c_SELDR: w_next = TMS ? c_SELIR : c_CAPDR;
            c_CAPDR: w_next = TMS ? c_EX1DR : c_SHDR;
            c_SHDR:  w_next = TMS ? c_EX1DR : c_SHDR;
            c_EX1DR: w_next = TMS ? c_UPDDR : c_PSDR;
            c_PSDR:  w_next = TMS ? c_EX2DR : c_PSDR;
            c_EX2DR: w_next = TMS ? c_UPDDR : c_SHDR;
            c_UPDDR: w_next = TMS ? c_SELDR : c_RTI;
            c_SELIR: w_next = TMS ? c_TLR   : c_CAPIR;
            c_CAPIR: w_next = TMS ? c_EX1IR : c_SHIR;
            c_SHIR:  w_next = TMS ? c_EX1IR : c_SHIR;
            c_EX1IR: w_next = TMS ? c_UPDIR : c_PSIR;
            c_PSIR:  w_next = TMS ? c_EX2IR : c_PSIR;
            c_EX2IR: w_next = TMS ? c_UPDIR : c_SHIR;
            c_UPDIR: w_next = TMS ? c_SELDR : c_RTI;
            default: w_next = c_TLR;
        endcase
    end

    // Register actions are keyed on the state being left at this edge
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_state  <= c_TLR;
            r_ir     <= IR_RESET;
            r_ir_sr  <= c_IR_CAPTURE;
            r_bypass <= 1'b0;
            r_id_sr  <= IDCODE_VALUE;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_TLR:   r_ir    <= IR_RESET;
                c_CAPIR: r_ir_sr <= c_IR_CAPTURE;
                c_SHIR:  r_ir_sr <= {TDI, r_ir_sr[3:1]};
                c_UPDIR: r_ir    <= r_ir_sr;
                c_CAPDR: begin
                    if (w_sel_id)
                        r_id_sr <= IDCODE_VALUE;
                    else if (!w_sel_dwr)
                        r_bypass <= 1'b0;
                end
                c_SHDR: begin
                    if (w_sel_id)
                        r_id_sr <= {TDI, r_id_sr[31:1]};
                    else if (!w_sel_dwr)
                        r_bypass <= TDI;
                end
                default: ;
            endcase
        end
    end

    assign w_shifting = (r_state == c_SHIR) || (r_state == c_SHDR);

    always_comb begin
        w_tdo = 1'b0;
        if (r_state == c_SHIR)
            w_tdo = r_ir_sr[0];
        else if (r_state == c_SHDR)
            w_tdo = w_sel_dwr ? wrapper_tdo : (w_sel_id ? r_id_sr[0] : r_bypass);
    end

    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo    <= w_tdo;
            r_tdo_en <= w_shifting;
        end
    end

    assign tap_state = r_state;
    assign IR        = r_ir;
    assign TDO       = r_tdo;
    assign tdo_en    = r_tdo_en;

endmodule
`default_nettype wire
